// File: rtl/key_redraw_scheduler.sv
// key_redraw_scheduler: redraws a 4-key keyboard region by region as key levels change.
// Define KEY_DEBOUNCE_EN to filter each key through a DEBOUNCE_CYCLES stability counter.
module key_redraw_scheduler #(
  parameter int REGION_W        = 40,
  parameter int SCREEN_H        = 120,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] keys_i,
  output logic       plot_o,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] colour_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int CXW = REGION_W > 1 ? $clog2(REGION_W) : 1;
  localparam int RW  = SCREEN_H > 1 ? $clog2(SCREEN_H) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] lvl_q, lvl_d, pend_q, pend_d, clr;
  logic [1:0] ptr_q, ptr_d, g_q, g_d, sel;
  logic flag_q, flag_d, plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic eol, last;
`ifdef KEY_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [3:0][DW-1:0] cnt_q, cnt_d;
  // A key's level flips only after the raw input has disagreed for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++)
      if (keys_i[i] == lvl_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d[i] = keys_i[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign lvl_d = keys_i;
`endif
  // Round-robin: scanning downward leaves the first pending index at or after ptr.
  always_comb begin
    sel = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (pend_q[ptr_q + 2'(i)]) sel = ptr_q + 2'(i);
  end
  assign eol  = cx_q == CXW'(REGION_W - 1);
  assign last = eol && row_q == RW'(SCREEN_H - 1);
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    flag_d   = flag_q;
    cx_d     = cx_q;
    row_d    = row_q;
    clr      = '0;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: state_d = |pend_q ? GRANT : IDLE;
      GRANT: begin
        g_d     = sel;
        flag_d  = lvl_q[sel];
        clr     = 4'b0001 << sel;
        ptr_d   = sel + 2'd1;
        cx_d    = '0;
        row_d   = '0;
        plot_d  = 1'b1;
        state_d = DRAW;
      end
      DRAW: begin
        state_d = last ? DONE : DRAW;
        plot_d  = !last;
        cx_d    = last ? cx_q : (eol ? '0 : cx_q + 1'b1);
        row_d   = (eol && !last) ? row_q + 1'b1 : row_q;
      end
      default: state_d = IDLE;
    endcase
    if (plot_d) begin
      x_d      = 8'(32'(g_d) * REGION_W + 32'(cx_d));
      y_d      = 7'(row_d);
      colour_d = cx_d == CXW'(REGION_W - 1) ? 3'b000 : (flag_d ? 3'b100 : 3'b111);
    end
    // A transition arriving with the grant clear keeps the bit set.
    pend_d = (pend_q & ~clr) | (lvl_d ^ lvl_q);
    busy_d = state_d == GRANT || state_d == DRAW;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= IDLE;
      pend_q   <= 4'hF;
      lvl_q    <= '0;
      ptr_q    <= '0;
      g_q      <= '0;
      flag_q   <= 1'b0;
      cx_q     <= '0;
      row_q    <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      lvl_q    <= lvl_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      flag_q   <= flag_d;
      cx_q     <= cx_d;
      row_q    <= row_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  assign plot_o   = plot_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
endmodule

// File: doc/key_redraw_scheduler.md
KEY_REDRAW_SCHEDULER -- requirements
Module: key_redraw_scheduler

Interface
REQ-001 Parameter REGION_W, default 40: pixel width of one key region, divider column included.
REQ-002 Parameter SCREEN_H, default 120: pixel rows per region.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stable cycles required per key (used only under KEY_DEBOUNCE_EN).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 keys  input  4  level key states; 1 = pressed; bit n selects region n.
REQ-007 plot  output  1  pixel write strobe for the VGA adapter.
REQ-008 x  output  8  pixel column, 0..4*REGION_W-1.
REQ-009 y  output  7  pixel row, 0..SCREEN_H-1.
REQ-010 colour  output  3  pixel colour: 000 black, 100 red, 111 white.
REQ-011 busy  output  1  high from GRANT through DRAW.
REQ-012 done  output  1  one-cycle pulse after the last pixel of a region.

Function
REQ-013 Every 0->1 or 1->0 transition of the effective key level n SHALL set pending[n].
REQ-014 States: IDLE, GRANT, DRAW, DONE; all outputs registered.
REQ-015 IDLE->GRANT when any pending bit is set; otherwise remain in IDLE.
REQ-016 GRANT: round-robin select of the lowest pending index at or after ptr (modulo 4); latch index g; snapshot keys[g] as pressed flag; clear pending[g]; ptr <= g+1 (mod 4).
REQ-017 A transition on key g in the same cycle as its GRANT clear SHALL leave pending[g] set (set wins).
REQ-018 GRANT->DRAW after exactly 1 cycle; first plot occurs in the cycle after GRANT.
REQ-019 DRAW emits one pixel per cycle, row-major: column offset cx 0..REGION_W-1 inner, row 0..SCREEN_H-1 outer; x = g*REGION_W+cx, y = row; plot=1.
REQ-020 colour = black when cx == REGION_W-1; otherwise red if the snapshot flag is set, else white.
REQ-021 DRAW lasts exactly REGION_W*SCREEN_H cycles (4800 at defaults); DRAW->DONE after pixel (REGION_W-1, SCREEN_H-1).
REQ-022 DONE: plot=0, done=1 for one cycle, busy=0; then IDLE.
REQ-023 Key changes during DRAW do not alter the region being drawn; they only set pending bits.
REQ-024 plot=0 in IDLE, GRANT and DONE; x, y and colour hold their last values when plot=0.
REQ-025 Counters SHALL not wrap: cx resets to 0 at REGION_W-1, and row increments only on that cycle.

Reset
REQ-026 Asserted reset: state=IDLE, plot=0, busy=0, done=0, x=0, y=0, colour=000, ptr=0, counters=0.
REQ-027 On reset, pending SHALL be 4'b1111 so the full keyboard is drawn after release; key-level history SHALL be loaded with 0.
REQ-028 Reset asserted mid-DRAW aborts immediately; no partial-region resumption.

Configuration
REQ-029 Macro KEY_DEBOUNCE_EN defined: each key passes through a DEBOUNCE_CYCLES counter; the effective level changes only after the raw input is stable for DEBOUNCE_CYCLES consecutive cycles.
REQ-030 KEY_DEBOUNCE_EN undefined: the effective level is keys registered through one flop; no counters are instantiated.

Verification
REQ-031 Release reset, keys=0 -> regions drawn in order 0,1,2,3; 4 done pulses; 19200 plots total; every pixel with x in {39,79,119,159} is black, all others white.
REQ-032 After idle, set keys[2]=1 -> GRANT g=2; first plot x=80,y=0 two cycles after the edge registers; x 80..118 red, x=119 black; 4800 plots; one done pulse.
REQ-033 Set keys[1] and keys[3] in the same cycle with ptr=2 -> region 3 drawn before region 1.
REQ-034 Toggle keys[0] 0->1->0 during a region-0 DRAW -> current region completes with its snapshot colour; region 0 redrawn once more afterwards, white.
REQ-035 Assert reset at plot 2000 of a region -> plot=0 asynchronously; after release, all 4 regions redraw.
REQ-036 With KEY_DEBOUNCE_EN, a 5-cycle glitch on keys[0] -> no pending set and no plots; a level held for 16 cycles -> region 0 redrawn.
